// File: rtl/dmem_pkg.sv
// Shared types, size codes and data lane helpers for the data memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_ACK   = 2'b11
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int unsigned DEPTH_DEF = 256;

    // The memory always writes 4 bytes, so sub-word stores keep the upper old bytes.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size);
        case (size)
            SZ_B:    return {old_word[31:8], wdata[7:0]};
            SZ_H:    return {old_word[31:16], wdata[15:0]};
            default: return wdata;
        endcase
    endfunction

    // Loads are returned zero-extended and LSB-aligned.
    function automatic logic [31:0] extract_load(input logic [31:0] old_word,
                                                 input logic [1:0]  size);
        case (size)
            SZ_B:    return {24'b0, old_word[7:0]};
            SZ_H:    return {16'b0, old_word[15:0]};
            default: return old_word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester port of the data memory arbiter.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, size, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, size, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_rr_arb.sv
// Two-requester round-robin arbiter; a grant is only issued while en_i is high.
module dmem_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);
    logic last_q, last_d;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        gnt_valid_o = en_i && (req0_i || req1_i);
        gnt_id_o    = 1'b0;
        if (req0_i && req1_i) begin
            gnt_id_o = ~last_q;
        end else if (req1_i) begin
            gnt_id_o = 1'b1;
        end
        last_d = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Last-grant register; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer sharing the DataMemory between two ports with range checks and
// read-modify-write for sub-word stores.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          mem_RW,
    output logic [AW-1:0] mem_Addr,
    output logic [DW-1:0] mem_DataIn,
    input  logic [DW-1:0] mem_DataOut
);
    localparam logic [AW-1:0] LAST_LEGAL = AW'(DEPTH - 4);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] old_q, old_d;
    logic          id_q, id_d;
    logic          err_q, err_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mdin_q, mdin_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          gnt_valid, gnt_id;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] rdata_nxt;

    dmem_rr_arb u_arb (
        .clk_i       (CLK),
        .rst_i       (RST),
        .en_i        (state_q == S_IDLE),
        .req0_i      (m0.req),
        .req1_i      (m1.req),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign sel_we    = gnt_id ? m1.we    : m0.we;
    assign sel_size  = gnt_id ? m1.size  : m0.size;
    assign sel_addr  = gnt_id ? m1.addr  : m0.addr;
    assign sel_wdata = gnt_id ? m1.wdata : m0.wdata;

    // Next state plus the registered values every output takes in that state.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        id_d    = id_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    we_d    = sel_we;
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    id_d    = gnt_id;
                    // Plain compare against DEPTH-4: no addition, so no wrap.
                    err_d   = (sel_size == 2'b11) || (sel_addr > LAST_LEGAL);
                    if (err_d) begin
                        state_d = S_ACK;
                    end else if (sel_we && sel_size == SZ_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                old_d   = mem_DataOut;
                state_d = we_q ? S_WRITE : S_ACK;
            end
            S_WRITE: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rw_d    = (state_d == S_WRITE);
        maddr_d = (state_d == S_READ || state_d == S_WRITE) ? addr_d : maddr_q;
        mdin_d  = (state_d == S_WRITE) ? merge_store(old_d, wdata_d, size_d) : mdin_q;

        rdata_nxt = (err_d || we_d) ? '0 : extract_load(old_d, size_d);
        ack0_d    = (state_d == S_ACK) && !id_d;
        ack1_d    = (state_d == S_ACK) && id_d;
        err0_d    = ack0_d && err_d;
        err1_d    = ack1_d && err_d;
        rdata0_d  = ack0_d ? rdata_nxt : '0;
        rdata1_d  = ack1_d ? rdata_nxt : '0;
    end

    // State and output registers; reset abandons any transaction without an ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_B;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            rw_q     <= 1'b0;
            maddr_q  <= '0;
            mdin_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            id_q     <= id_d;
            err_q    <= err_d;
            rw_q     <= rw_d;
            maddr_q  <= maddr_d;
            mdin_q   <= mdin_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem_RW     = rw_q;
    assign mem_Addr   = maddr_q;
    assign mem_DataIn = mdin_q;
    assign m0.ack     = ack0_q;
    assign m0.err     = err0_q;
    assign m0.rdata   = rdata0_q;
    assign m1.ack     = ack1_q;
    assign m1.err     = err1_q;
    assign m1.rdata   = rdata1_q;
endmodule
